alu_seq_unit: RTL and testbench

Parametrised, registered successor to the team's 16-bit combinational ALU. It executes the same seven operations with a persistent carry flag, so ADC chains across operations, and adds an iterative multiply. Operand/result transfer uses valid/ready handshakes on both sides. It sits between the register-file read stage and the writeback stage of the datapath.

---
 rtl/alu_seq_pkg.sv | 21 ++
 rtl/alu_seq_mul.sv | 66 ++++++
 rtl/alu_seq_unit.sv | 163 ++++++++++++++++
 tb/tb_alu_seq_unit.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared types for the registered ALU: opcode encoding and multiply sequencing states.
package alu_seq_pkg;

   typedef enum logic [2:0] {
      NEGINC = 3'd0,
      INC    = 3'd1,
      ADC    = 3'd2,
      ADDSHR = 3'd3,
      AND_OP = 3'd4,
      OR_OP  = 3'd5,
      PACK   = 3'd6,
      MUL    = 3'd7
   } opcode_t;

   typedef enum logic [1:0] {
      IDLE,
      MUL_RUN,
      MUL_DONE
   } mul_state_t;

endpackage

// File: rtl/alu_seq_mul.sv
// Iterative shift-add multiplier: one partial product per cycle, WIDTH cycles per run.
module alu_seq_mul
   import alu_seq_pkg::*;
#(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic             done_o,
   output logic [WIDTH-1:0] prod_o
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

   logic [WIDTH-1:0] mcand_q, mcand_d;
   logic [WIDTH-1:0] mplier_q, mplier_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             run_q, run_d;

   always_comb begin
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      run_d    = run_q;
      if (start_i) begin
         mcand_d  = a_i;
         mplier_d = b_i;
         acc_d    = '0;
         cnt_d    = '0;
         run_d    = 1'b1;
      end else if (run_q) begin
         if (mplier_q[0]) acc_d = acc_q + mcand_q;
         mcand_d  = mcand_q << 1;
         mplier_d = mplier_q >> 1;
         cnt_d    = cnt_q + CNT_W'(1);
         if (cnt_q == LAST) run_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         run_q    <= 1'b0;
      end else begin
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         run_q    <= run_d;
      end
   end

   // Flags the final iteration so the sequencer leaves MUL_RUN on the same edge acc settles.
   assign done_o = run_q && (cnt_q == LAST);
   assign prod_o = acc_q;

endmodule

// File: rtl/alu_seq_unit.sv
// Registered ALU with persistent carry, iterative multiply and valid/ready on both sides.
module alu_seq_unit
   import alu_seq_pkg::*;
#(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       opcode,
   input  logic [WIDTH-1:0] inpA,
   input  logic [WIDTH-1:0] inpB,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] outW,
   output logic             zero,
   output logic             negative,
   output logic             carry
);

   mul_state_t       state_q, state_d;
   logic [WIDTH-1:0] out_q, out_d;
   logic             valid_q, valid_d;
   logic             zero_q, zero_d;
   logic             neg_q, neg_d;
   logic             carry_q, carry_d;

   opcode_t          op;
   logic             out_free, accept;
   logic [WIDTH-1:0] add_a, add_b;
   logic             add_cin;
   logic [WIDTH:0]   sum;
   logic [WIDTH-1:0] op_res;
   logic             op_sets_carry;
   logic             mul_start, mul_done;
   logic [WIDTH-1:0] mul_prod;
   logic             load;
   logic [WIDTH-1:0] load_val;

   assign op       = opcode_t'(opcode);
   assign out_free = !valid_q || out_ready;
   assign in_ready = !rst && (state_q == IDLE) && out_free;
   assign accept   = in_valid && in_ready;

   // The four carry-producing ops share one WIDTH+1 adder; cout is sum[WIDTH].
   always_comb begin
      add_a   = inpA;
      add_b   = '0;
      add_cin = 1'b0;
      case (op)
         NEGINC: begin
            add_a   = ~inpA;
            add_cin = 1'b1;
         end
         INC:    add_cin = 1'b1;
         ADC: begin
            add_b   = inpB;
            add_cin = carry_q;
         end
         ADDSHR: add_b = $signed(inpB) >>> 1;
         default: ;
      endcase
   end

   assign sum = {1'b0, add_a} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_cin};

   always_comb begin
      op_res = sum[WIDTH-1:0];
      case (op)
         AND_OP:  op_res = inpA & inpB;
         OR_OP:   op_res = inpA | inpB;
         PACK:    op_res = {inpA[WIDTH/2-1:0], inpB[WIDTH/2-1:0]};
         default: ;
      endcase
   end

   assign op_sets_carry = (op == NEGINC) || (op == INC) || (op == ADC) || (op == ADDSHR);

   always_comb begin
      state_d   = state_q;
      out_d     = out_q;
      valid_d   = valid_q;
      zero_d    = zero_q;
      neg_d     = neg_q;
      carry_d   = carry_q;
      mul_start = 1'b0;
      load      = 1'b0;
      load_val  = op_res;
      case (state_q)
         IDLE: begin
            if (accept) begin
               if (op == MUL) begin
                  mul_start = 1'b1;
                  state_d   = MUL_RUN;
               end else begin
                  load = 1'b1;
                  if (op_sets_carry) carry_d = sum[WIDTH];
               end
            end
         end
         MUL_RUN: begin
            if (mul_done) state_d = MUL_DONE;
         end
         MUL_DONE: begin
            if (out_free) begin
               load     = 1'b1;
               load_val = mul_prod;
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      // A load on a draining edge replaces the old result, so valid stays high.
      if (load) begin
         out_d   = load_val;
         valid_d = 1'b1;
         zero_d  = (load_val == '0);
         neg_d   = load_val[WIDTH-1];
      end else if (out_ready) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         out_q   <= '0;
         valid_q <= 1'b0;
         zero_q  <= 1'b0;
         neg_q   <= 1'b0;
         carry_q <= 1'b0;
      end else begin
         state_q <= state_d;
         out_q   <= out_d;
         valid_q <= valid_d;
         zero_q  <= zero_d;
         neg_q   <= neg_d;
         carry_q <= carry_d;
      end
   end

   alu_seq_mul #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
   ) u_mul (
      .clk     (clk),
      .rst     (rst),
      .start_i (mul_start),
      .a_i     (inpA),
      .b_i     (inpB),
      .done_o  (mul_done),
      .prod_o  (mul_prod)
   );

   assign outW      = out_q;
   assign out_valid = valid_q;
   assign zero      = zero_q;
   assign negative  = neg_q;
   assign carry     = carry_q;

endmodule

// File: tb/tb_alu_seq_unit.sv
// Bench for alu_seq_unit: directed plan with literal expectations plus randomized traffic vs a behavioural model.
module tb_alu_seq_unit;

   localparam int unsigned W = 16;

   logic         clk = 1'b0;
   logic         rst, in_valid, out_ready;
   logic [2:0]   opcode;
   logic [W-1:0] inpA, inpB, outW;
   logic         in_ready, out_valid, zero, negative, carry;

   int checks = 0;
   int errors = 0;
   bit cmp_en = 1'b0;

   always #5 clk = ~clk;

   alu_seq_unit #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .opcode    (opcode),
      .inpA      (inpA),
      .inpB      (inpB),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .outW      (outW),
      .zero      (zero),
      .negative  (negative),
      .carry     (carry)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Reference arithmetic for single-cycle ops, written from the opcode definitions.
   function automatic void ref_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic cin, output logic [W-1:0] r, output logic cout,
                                  output logic upd);
      int unsigned  s;
      int           sb;
      logic [W-1:0] na, half;
      s = 0; upd = 1'b1; r = '0; cout = 1'b0;
      case (op)
         3'd0: begin na = ~a; s = na + 1; end
         3'd1: s = a + 1;
         3'd2: s = a + b + cin;
         3'd3: begin sb = $signed(b) >>> 1; half = sb[W-1:0]; s = a + half; end
         3'd4: begin upd = 1'b0; r = a & b; end
         3'd5: begin upd = 1'b0; r = a | b; end
         default: begin upd = 1'b0; r = {a[W/2-1:0], b[W/2-1:0]}; end
      endcase
      if (upd) begin r = s[W-1:0]; cout = s[W]; end
   endfunction

   logic [W-1:0] m_out   = '0;
   logic         m_valid = 1'b0;
   logic         m_carry = 1'b0;
   logic         m_busy  = 1'b0;
   logic [W-1:0] m_prod  = '0;
   longint       m_due   = 0;
   longint       cyc     = 0;

   always @(posedge clk) begin : model
      logic [W-1:0] r;
      logic co, upd, free, loaded;
      if (rst) begin
         m_valid = 1'b0; m_out = '0; m_carry = 1'b0; m_busy = 1'b0;
      end else begin
         free   = !m_valid || out_ready;
         loaded = 1'b0;
         if (m_busy) begin
            if (cyc >= m_due && free) begin
               m_out = m_prod; m_valid = 1'b1; m_busy = 1'b0; loaded = 1'b1;
            end
         end else if (free && in_valid) begin
            if (opcode == 3'd7) begin
               m_busy = 1'b1;
               m_prod = inpA * inpB;
               m_due  = cyc + W + 1;
            end else begin
               ref_op(opcode, inpA, inpB, m_carry, r, co, upd);
               m_out = r; m_valid = 1'b1; loaded = 1'b1;
               if (upd) m_carry = co;
            end
         end
         if (!loaded && m_valid && out_ready) m_valid = 1'b0;
      end
      cyc++;
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         chk("m_in_ready", in_ready, !rst && !m_busy && (!m_valid || out_ready));
         chk("m_out_valid", out_valid, m_valid);
         chk("m_carry", carry, m_carry);
         if (m_valid) begin
            chk("m_outW", outW, m_out);
            chk("m_zero", zero, m_out == '0);
            chk("m_negative", negative, m_out[W-1]);
         end
      end
   end

   task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      int n = 0;
      in_valid = 1'b1; opcode = op; inpA = a; inpB = b;
      @(negedge clk);
      while (!in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         checks++; errors++;
         $display("FAIL issue_timeout actual=%0d required=<100", n);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   function automatic logic [W-1:0] rnd_operand();
      case ($urandom_range(0, 7))
         0: return '0;
         1: return '1;
         2: return 16'h8000;
         3: return 16'h7FFF;
         default: return W'($urandom);
      endcase
   endfunction

   initial begin
      int  k;
      bit  ir_ok, stale, took;
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; opcode = '0; inpA = '0; inpB = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_outW", outW, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_zero", zero, 0);
      chk("rst_negative", negative, 0);
      chk("rst_carry", carry, 0);
      chk("rst_in_ready", in_ready, 0);
      rst = 1'b0;
      cmp_en = 1'b1;
      #1 chk("post_rst_in_ready", in_ready, 1);

      issue(3'd0, 16'h0005, 16'h0000);
      chk("neginc5_outW", outW, 16'hFFFB);
      chk("neginc5_neg", negative, 1);
      chk("neginc5_zero", zero, 0);
      chk("neginc5_carry", carry, 0);
      chk("neginc5_valid", out_valid, 1);

      issue(3'd0, 16'h0000, 16'h0000);
      chk("neginc0_outW", outW, 16'h0000);
      chk("neginc0_zero", zero, 1);
      chk("neginc0_carry", carry, 1);
      issue(3'd4, 16'hF0F0, 16'h0FF0);
      chk("and_outW", outW, 16'h00F0);
      chk("and_carry", carry, 1);

      issue(3'd1, 16'h0000, 16'h0000);
      chk("inc_carry", carry, 0);
      issue(3'd2, 16'hFFFF, 16'h0001);
      chk("adc1_outW", outW, 16'h0000);
      chk("adc1_carry", carry, 1);
      chk("adc1_zero", zero, 1);
      issue(3'd2, 16'h0001, 16'h0001);
      chk("adc2_outW", outW, 16'h0003);
      chk("adc2_carry", carry, 0);

      issue(3'd7, 16'hFFFD, 16'h0007);
      k = 0; ir_ok = 1'b1;
      while (!out_valid && k < 40) begin
         if (in_ready) ir_ok = 1'b0;
         @(posedge clk); #1;
         k++;
      end
      chk("mul_latency", k, 17);
      chk("mul_outW", outW, 16'hFFEB);
      chk("mul_negative", negative, 1);
      chk("mul_carry", carry, 0);
      chk("mul_in_ready_low", ir_ok, 1);

      @(posedge clk); #1;
      out_ready = 1'b0;
      issue(3'd6, 16'h12AB, 16'h34CD);
      chk("pack_outW", outW, 16'hABCD);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         chk("bp_outW", outW, 16'hABCD);
         chk("bp_in_ready", in_ready, 0);
         chk("bp_valid", out_valid, 1);
      end
      out_ready = 1'b1;
      issue(3'd3, 16'h0010, 16'hFFF0);
      chk("addshr_outW", outW, 16'h0008);
      chk("addshr_carry", carry, 1);
      chk("addshr_valid", out_valid, 1);

      issue(3'd7, 16'h1234, 16'h5678);
      repeat (5) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      chk("abort_valid", out_valid, 0);
      chk("abort_carry", carry, 0);
      chk("abort_in_ready", in_ready, 1);
      stale = 1'b0;
      repeat (30) begin
         @(posedge clk); #1;
         if (out_valid) stale = 1'b1;
      end
      chk("abort_no_stale", stale, 0);

      took = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         if (!in_valid || took) begin
            in_valid = ($urandom_range(0, 3) != 0);
            opcode   = 3'($urandom_range(0, 7));
            inpA     = rnd_operand();
            inpB     = rnd_operand();
         end
         out_ready = ($urandom_range(0, 3) != 0);
         rst       = ($urandom_range(0, 199) == 0);
         @(negedge clk);
         took = in_valid && in_ready;
         @(posedge clk); #1;
      end
      rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
